// File: rtl/rf_access_ctrl_if.sv
// Bundle between the read/write requesters, the access controller and the 32x32 register file.
// The controller takes the slave view; the requesters and the file model take the master view.
interface rf_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr1;
  logic [ADDR_WIDTH-1:0] rd_addr2;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic [DATA_WIDTH-1:0] rd_data2;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic                  rf_read;
  logic                  rf_write;
  logic [ADDR_WIDTH-1:0] rf_addr_r1;
  logic [ADDR_WIDTH-1:0] rf_addr_r2;
  logic [ADDR_WIDTH-1:0] rf_addr_w;
  logic [DATA_WIDTH-1:0] rf_data_w;
  logic [DATA_WIDTH-1:0] rf_data_r1;
  logic [DATA_WIDTH-1:0] rf_data_r2;
  logic                  busy;

  modport slave (
    input  rd_req, rd_addr1, rd_addr2, wr_req, wr_addr, wr_data, rf_data_r1, rf_data_r2,
    output rd_ack, rd_data1, rd_data2, wr_ack, rf_read, rf_write,
           rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w, busy
  );

  modport master (
    output rd_req, rd_addr1, rd_addr2, wr_req, wr_addr, wr_data, rf_data_r1, rf_data_r2,
    input  rd_ack, rd_data1, rd_data2, wr_ack, rf_read, rf_write,
           rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w, busy
  );
endinterface

// File: rtl/rf_access_ctrl.sv
// Serialises a dual-operand read port and a write port onto the register file's shared
// READ/WRITE control, with write priority bounded by a consecutive-write limit.
module rf_access_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_access_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_ISSUE = 2'd1;
  localparam logic [1:0] RD_CAPT  = 2'd2;
  localparam logic [1:0] WR_ISSUE = 2'd3;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_WR_STREAK);

  logic [1:0]            state_reg;
  logic [2:0]            wr_streak_reg;
  logic                  rd_ack_reg;
  logic                  wr_ack_reg;
  logic [DATA_WIDTH-1:0] rd_data1_reg;
  logic [DATA_WIDTH-1:0] rd_data2_reg;
  logic [ADDR_WIDTH-1:0] addr_r1_reg;
  logic [ADDR_WIDTH-1:0] addr_r2_reg;
  logic [ADDR_WIDTH-1:0] addr_w_reg;
  logic [DATA_WIDTH-1:0] data_w_reg;

  logic       rd_eligible;
  logic       wr_eligible;
  logic       grant_wr;
  logic       grant_rd;
  logic [2:0] wr_streak_next;

  // A requester still showing its ack this cycle is holding a stale request; skip it.
  always_comb begin
    rd_eligible = bus.rd_req & ~rd_ack_reg;
    wr_eligible = bus.wr_req & ~wr_ack_reg;
    grant_wr    = (state_reg == IDLE) & wr_eligible &
                  (~rd_eligible | (wr_streak_reg != STREAK_MAX));
    grant_rd    = (state_reg == IDLE) & rd_eligible & ~grant_wr;
    if (!rd_eligible) begin
      wr_streak_next = 3'd0;
    end else if (wr_streak_reg == STREAK_MAX) begin
      wr_streak_next = STREAK_MAX;
    end else begin
      wr_streak_next = wr_streak_reg + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_streak_reg <= 3'd0;
      rd_ack_reg    <= 1'b0;
      wr_ack_reg    <= 1'b0;
      rd_data1_reg  <= '0;
      rd_data2_reg  <= '0;
      addr_r1_reg   <= '0;
      addr_r2_reg   <= '0;
      addr_w_reg    <= '0;
      data_w_reg    <= '0;
    end else begin
      rd_ack_reg <= 1'b0;
      wr_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_wr) begin
            state_reg     <= WR_ISSUE;
            addr_w_reg    <= bus.wr_addr;
            data_w_reg    <= bus.wr_data;
            wr_streak_reg <= wr_streak_next;
          end else if (grant_rd) begin
            state_reg     <= RD_ISSUE;
            addr_r1_reg   <= bus.rd_addr1;
            addr_r2_reg   <= bus.rd_addr2;
            wr_streak_reg <= 3'd0;
          end
        end
        RD_ISSUE: state_reg <= RD_CAPT;
        // File outputs have settled after a full cycle of READ; sample them now.
        RD_CAPT: begin
          rd_data1_reg <= bus.rf_data_r1;
          rd_data2_reg <= bus.rf_data_r2;
          rd_ack_reg   <= 1'b1;
          state_reg    <= IDLE;
        end
        WR_ISSUE: begin
          wr_ack_reg <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Control strobes decode straight from state so an asynchronous reset clears them at once.
  assign bus.rf_read    = (state_reg == RD_ISSUE) | (state_reg == RD_CAPT);
  assign bus.rf_write   = (state_reg == WR_ISSUE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.rd_ack     = rd_ack_reg;
  assign bus.wr_ack     = wr_ack_reg;
  assign bus.rd_data1   = rd_data1_reg;
  assign bus.rd_data2   = rd_data2_reg;
  assign bus.rf_addr_r1 = addr_r1_reg;
  assign bus.rf_addr_r2 = addr_r2_reg;
  assign bus.rf_addr_w  = addr_w_reg;
  assign bus.rf_data_w  = data_w_reg;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: register-file model, protocol-following requesters and a
// transaction-level reference model compared every cycle.
module tb_rf_access_ctrl;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rf_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WR_STREAK(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file model: outputs garbage when READ is low so a mistimed capture shows up.
  logic [DW-1:0] rf_mem [32];
  assign bus.rf_data_r1 = bus.rf_read ? rf_mem[bus.rf_addr_r1] : 32'hBAD0_0BAD;
  assign bus.rf_data_r2 = bus.rf_read ? rf_mem[bus.rf_addr_r2] : 32'hBAD0_0BAD;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an operation occupies the file for a fixed number of cycles.
  int            m_left;
  bit            m_op_rd;
  bit            m_rd_ack, m_wr_ack, m_g_rd, m_g_wr;
  int            m_streak, m_rd_acks, m_wr_acks;
  logic [AW-1:0] m_ra1, m_ra2, m_wa;
  logic [DW-1:0] m_wd, m_rd1, m_rd2;
  logic [DW-1:0] shadow [32];

  // Requester / observation state
  bit            want_rd, want_wr, rnd_mode, wr_auto;
  logic [AW-1:0] nx_ra1, nx_ra2, nx_wa;
  logic [DW-1:0] nx_wd;
  bit            seen_rd_ack, seen_wr_ack;
  int            rd_raised, wr_raised, rd_acks_seen, wr_acks_seen;
  int            cyc, cnt_rfr, cnt_rfw, cnt_busy, last_rd_ack_cyc, last_wr_ack_cyc;
  logic [AW-1:0] wa_when_write;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  task automatic model_reset();
    m_left = 0; m_op_rd = 0; m_rd_ack = 0; m_wr_ack = 0; m_streak = 0;
    m_ra1 = '0; m_ra2 = '0; m_wa = '0; m_wd = '0; m_rd1 = '0; m_rd2 = '0;
  endtask

  task automatic model_edge();
    bit rd_el, wr_el;
    m_g_rd = 0;
    m_g_wr = 0;
    if (rst) begin
      model_reset();
      return;
    end
    rd_el = bus.rd_req && !m_rd_ack;
    wr_el = bus.wr_req && !m_wr_ack;
    m_rd_ack = 0;
    m_wr_ack = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_op_rd) begin
          m_rd_ack = 1; m_rd1 = shadow[m_ra1]; m_rd2 = shadow[m_ra2]; m_rd_acks++;
        end else begin
          m_wr_ack = 1; m_wr_acks++;
        end
      end
    end else if (wr_el && (!rd_el || m_streak < MAXS)) begin
      m_g_wr = 1; m_op_rd = 0; m_left = 1;
      m_wa = bus.wr_addr; m_wd = bus.wr_data; shadow[m_wa] = m_wd;
      m_streak = rd_el ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
    end else if (rd_el) begin
      m_g_rd = 1; m_op_rd = 1; m_left = 2;
      m_ra1 = bus.rd_addr1; m_ra2 = bus.rd_addr2; m_streak = 0;
    end
  endtask

  task automatic check_outputs();
    chk("busy",       32'(bus.busy),       32'(m_left > 0));
    chk("rf_read",    32'(bus.rf_read),    32'(m_left > 0 && m_op_rd));
    chk("rf_write",   32'(bus.rf_write),   32'(m_left > 0 && !m_op_rd));
    chk("rw_excl",    32'(bus.rf_read & bus.rf_write), 32'd0);
    chk("rd_ack",     32'(bus.rd_ack),     32'(m_rd_ack));
    chk("wr_ack",     32'(bus.wr_ack),     32'(m_wr_ack));
    chk("rd_data1",   bus.rd_data1,        m_rd1);
    chk("rd_data2",   bus.rd_data2,        m_rd2);
    chk("rf_addr_r1", 32'(bus.rf_addr_r1), 32'(m_ra1));
    chk("rf_addr_r2", 32'(bus.rf_addr_r2), 32'(m_ra2));
    chk("rf_addr_w",  32'(bus.rf_addr_w),  32'(m_wa));
    chk("rf_data_w",  bus.rf_data_w,       m_wd);
    seen_rd_ack = bus.rd_ack;
    seen_wr_ack = bus.wr_ack;
    if (bus.rd_ack) begin rd_acks_seen++; last_rd_ack_cyc = cyc; end
    if (bus.wr_ack) begin wr_acks_seen++; last_wr_ack_cyc = cyc; end
    cnt_rfr  += 32'(bus.rf_read);
    cnt_rfw  += 32'(bus.rf_write);
    cnt_busy += 32'(bus.busy);
    if (bus.rf_write) begin
      wa_when_write = bus.rf_addr_w;
      rf_mem[bus.rf_addr_w] = bus.rf_data_w;
    end
  endtask

  task automatic cycle();
    bit drop_r, drop_w;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    drop_r = 0;
    drop_w = 0;
    if (bus.rd_req && seen_rd_ack) begin bus.rd_req = 1'b0; drop_r = 1; end
    if (bus.wr_req && seen_wr_ack) begin bus.wr_req = 1'b0; drop_w = 1; end
    // Payload is free to change once granted.
    if (bus.rd_req && m_g_rd) begin
      bus.rd_addr1 = AW'($urandom); bus.rd_addr2 = AW'($urandom);
    end
    if (bus.wr_req && m_g_wr) begin
      bus.wr_addr = AW'($urandom); bus.wr_data = $urandom;
    end
    if (rnd_mode) begin
      if (!want_rd && $urandom_range(0, 99) < 30) begin
        want_rd = 1; nx_ra1 = AW'($urandom_range(0, 31)); nx_ra2 = AW'($urandom_range(0, 31));
      end
      if (!want_wr && $urandom_range(0, 99) < 30) begin
        want_wr = 1; nx_wa = AW'($urandom_range(0, 31)); nx_wd = $urandom;
      end
    end
    if (wr_auto && !want_wr) begin
      want_wr = 1; nx_wa = AW'($urandom_range(16, 31)); nx_wd = $urandom;
    end
    if (want_rd && !bus.rd_req && !drop_r) begin
      bus.rd_req = 1'b1; bus.rd_addr1 = nx_ra1; bus.rd_addr2 = nx_ra2;
      want_rd = 0; rd_raised++;
    end
    if (want_wr && !bus.wr_req && !drop_w) begin
      bus.wr_req = 1'b1; bus.wr_addr = nx_wa; bus.wr_data = nx_wd;
      want_wr = 0; wr_raised++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_until_rd_ack(input int maxc, input string tag);
    int start = rd_acks_seen;
    for (int n = 0; n < maxc && rd_acks_seen == start; n++) cycle();
    chk(tag, 32'(rd_acks_seen - start), 32'd1);
  endtask

  task automatic run_until_wr_ack(input int maxc, input string tag);
    int start = wr_acks_seen;
    for (int n = 0; n < maxc && wr_acks_seen == start; n++) cycle();
    chk(tag, 32'(wr_acks_seen - start), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (n < 60 && (bus.rd_req || bus.wr_req || want_rd || want_wr || m_left > 0)) begin
      cycle();
      n++;
    end
    chk(tag, 32'(bus.rd_req || bus.wr_req || m_left > 0), 32'd0);
  endtask

  initial begin
    int b0, w0, r0, wa0, mw0, ra0;
    for (int i = 0; i < 32; i++) begin rf_mem[i] = '0; shadow[i] = '0; end
    model_reset();
    bus.rd_req = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;

    // Single write 5 <- DEADBEEF
    want_wr = 1; nx_wa = 5'd5; nx_wd = 32'hDEADBEEF;
    b0 = cnt_busy; w0 = cnt_rfw;
    run_until_wr_ack(10, "wr1_ack");
    chk("wr1_rf_write_cycles", 32'(cnt_rfw - w0), 32'd1);
    chk("wr1_busy_cycles",     32'(cnt_busy - b0), 32'd1);
    chk("wr1_rf_addr_w",       32'(wa_when_write), 32'd5);

    // Read 5 and 0
    want_rd = 1; nx_ra1 = 5'd5; nx_ra2 = 5'd0;
    r0 = cnt_rfr;
    run_until_rd_ack(10, "rd1_ack");
    chk("rd1_rf_read_cycles", 32'(cnt_rfr - r0), 32'd2);
    chk("rd1_data1", bus.rd_data1, 32'hDEADBEEF);
    chk("rd1_data2", bus.rd_data2, 32'd0);
    drain("drain_after_rd1");

    // Simultaneous write 7 <- 1234 and read of 7: write first
    want_wr = 1; nx_wa = 5'd7; nx_wd = 32'h1234;
    want_rd = 1; nx_ra1 = 5'd7; nx_ra2 = 5'd7;
    run_until_rd_ack(20, "both_rd_ack");
    chk("both_wr_first", 32'(last_wr_ack_cyc < last_rd_ack_cyc), 32'd1);
    chk("both_rd_data1", bus.rd_data1, 32'h1234);
    chk("both_rd_data2", bus.rd_data2, 32'h1234);
    drain("drain_after_both");

    // Writes continuously re-requested with a read pending
    wr_auto = 1;
    wa0 = wr_acks_seen; mw0 = m_wr_acks;
    want_rd = 1; nx_ra1 = 5'd1; nx_ra2 = 5'd2;
    run_until_rd_ack(60, "streak_rd_ack");
    chk("streak_wr_before_rd", 32'(wr_acks_seen - wa0), 32'(m_wr_acks - mw0));
    wa0 = wr_acks_seen;
    repeat (12) cycle();
    chk("streak_writes_resume", 32'(wr_acks_seen > wa0), 32'd1);
    wr_auto = 0;
    drain("drain_after_streak");

    // Asynchronous reset during the capture cycle of a read
    want_rd = 1; nx_ra1 = 5'd7; nx_ra2 = 5'd5;
    for (int n = 0; n < 20 && !(m_op_rd && m_left == 1); n++) cycle();
    chk("reach_rd_capt", 32'(m_op_rd && m_left == 1), 32'd1);
    ra0 = rd_acks_seen;
    rst = 1'b1;
    #1;
    chk("rst_rf_read",  32'(bus.rf_read), 32'd0);
    chk("rst_busy",     32'(bus.busy),    32'd0);
    chk("rst_rd_ack",   32'(bus.rd_ack),  32'd0);
    chk("rst_rd_data1", bus.rd_data1,     32'd0);
    chk("rst_addr_r1",  32'(bus.rf_addr_r1), 32'd0);
    chk("rst_data_w",   bus.rf_data_w,    32'd0);
    model_reset();
    bus.rd_req = 1'b0; rd_raised--; want_rd = 1;
    seen_rd_ack = 0; seen_wr_ack = 0;
    cycle();
    rst = 1'b0;
    chk("rst_no_rd_ack", 32'(rd_acks_seen - ra0), 32'd0);
    run_until_rd_ack(20, "reissue_rd_ack");
    chk("reissue_data1", bus.rd_data1, 32'h1234);
    chk("reissue_data2", bus.rd_data2, 32'hDEADBEEF);
    drain("drain_after_rst");

    // Random traffic
    rnd_mode = 1;
    repeat (10000) cycle();
    rnd_mode = 0;
    drain("drain_after_random");
    chk("rd_one_ack_per_req", 32'(rd_acks_seen), 32'(rd_raised));
    chk("wr_one_ack_per_req", 32'(wr_acks_seen), 32'(wr_raised));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
